// File: rtl/uart_reg_master_if.sv
// Request/response bus between a host and the UART register master.
interface uart_reg_master_if;
    logic       req_valid_in;
    logic       req_ready_out;
    logic       req_write_in;
    logic [6:0] req_addr_in;
    logic [7:0] req_wdata_in;
    logic       rsp_valid_out;
    logic [7:0] rsp_rdata_out;
    logic       rsp_err_out;
    logic       busy_out;

    // Master issues requests and receives responses; slave is the UART master block.
    modport master (
        output req_valid_in, req_write_in, req_addr_in, req_wdata_in,
        input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out, busy_out
    );

    modport slave (
        input  req_valid_in, req_write_in, req_addr_in, req_wdata_in,
        output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out, busy_out
    );
endinterface

// File: rtl/uart_reg_master.sv
// UART command initiator: serialises register read/write requests as 8N1
// frames on tx_out and collects the one-byte reply from rx_in.
module uart_reg_master #(
    parameter int unsigned CLKS_PER_BIT = 142,
    parameter int unsigned RSP_TIMEOUT  = 20000
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    uart_reg_master_if.slave  bus,
    output logic              tx_out,
    input  logic              rx_in
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TO_W  = $clog2(RSP_TIMEOUT + 1);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, SEND_DATA, WAIT_RSP, RECV, DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [3:0]       r_bit_idx;
    logic [TO_W-1:0]  r_to_cnt;
    logic [9:0]       r_frame;
    logic             r_tx;
    logic             r_wr;
    logic [7:0]       r_wdata;
    logic [7:0]       r_rx_byte;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_d;
    logic             r_ready;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_rdata;
    logic             r_rsp_err;
    logic             w_hs;
    logic             w_bit_end;
    logic             w_bit_last;
    logic             w_half;
    logic             w_fall;
    logic             w_to_hit;
    logic [7:0]       w_rsp_rdata;
    logic             w_rsp_err;

    assign w_hs       = bus.req_valid_in & r_ready;
    assign w_bit_end  = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_half     = (r_clk_cnt == CNT_W'(HALF - 1));
    assign w_bit_last = (r_bit_idx == 4'd9);
    assign w_fall     = r_rx_d & ~r_rx_s2;
    assign w_to_hit   = (r_to_cnt == TO_W'(RSP_TIMEOUT - 1));

    assign tx_out            = r_tx;
    assign bus.req_ready_out = r_ready;
    assign bus.busy_out      = r_busy;
    assign bus.rsp_valid_out = r_rsp_valid;
    assign bus.rsp_rdata_out = r_rsp_rdata;
    assign bus.rsp_err_out   = r_rsp_err;

    // State register.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state and response value selection; timeout default is err with zero data.
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_rdata = 8'h00;
        w_rsp_err   = 1'b1;
        case (r_state)
            IDLE:      if (w_hs) w_state_nxt = SEND_CMD;
            SEND_CMD:  if (w_bit_end && w_bit_last) w_state_nxt = r_wr ? SEND_DATA : WAIT_RSP;
            SEND_DATA: if (w_bit_end && w_bit_last) w_state_nxt = WAIT_RSP;
            WAIT_RSP: begin
                if (w_fall)        w_state_nxt = RECV;
                else if (w_to_hit) w_state_nxt = DONE;
            end
            RECV: begin
                if (r_bit_idx == 4'd0) begin
                    if (w_half && r_rx_s2) w_state_nxt = WAIT_RSP;
                end else if (w_bit_end && w_bit_last) begin
                    w_state_nxt = DONE;
                    w_rsp_rdata = r_rx_byte;
                    w_rsp_err   = ~r_rx_s2 | (r_wr & (r_rx_byte != 8'hAA));
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: bit timing, TX shifter, RX synchroniser/shifter, timeout and response registers.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_to_cnt    <= '0;
            r_frame     <= '1;
            r_tx        <= 1'b1;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_rx_byte   <= '0;
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_d      <= 1'b1;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rx_s1     <= rx_in;
            r_rx_s2     <= r_rx_s1;
            r_rx_d      <= r_rx_s2;
            r_ready     <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_rsp_valid <= (w_state_nxt == DONE);
            if (r_state != DONE && w_state_nxt == DONE) begin
                r_rsp_rdata <= w_rsp_rdata;
                r_rsp_err   <= w_rsp_err;
            end
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_wr      <= bus.req_write_in;
                        r_wdata   <= bus.req_wdata_in;
                        r_frame   <= {1'b1, bus.req_write_in, bus.req_addr_in, 1'b0};
                        r_tx      <= 1'b0;
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                    end
                end
                SEND_CMD, SEND_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (w_bit_last) begin
                            r_bit_idx <= '0;
                            if (r_state == SEND_CMD && r_wr) begin
                                r_frame <= {1'b1, r_wdata, 1'b0};
                                r_tx    <= 1'b0;
                            end else begin
                                r_tx     <= 1'b1;
                                r_to_cnt <= '0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_tx      <= r_frame[1];
                            r_frame   <= {1'b1, r_frame[9:1]};
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                WAIT_RSP: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (w_fall) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                    end
                end
                RECV: begin
                    if (r_bit_idx == 4'd0) begin
                        if (w_half) begin
                            r_clk_cnt <= '0;
                            r_bit_idx <= 4'd1;
                        end else begin
                            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                        end
                    end else if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (!w_bit_last) r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master with CLKS_PER_BIT=4 and RSP_TIMEOUT=50.
module tb_uart_reg_master;

    localparam int unsigned CPB = 4;

    logic clk_in;
    logic rst_in_n;
    logic tx_out;
    logic rx_in;

    uart_reg_master_if bus_if ();

    uart_reg_master #(.CLKS_PER_BIT(CPB), .RSP_TIMEOUT(50)) dut (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .bus      (bus_if),
        .tx_out   (tx_out),
        .rx_in    (rx_in)
    );

    int unsigned cyc = 0;
    int          compared = 0;
    int          failed = 0;
    int          mon_cnt = 0;
    int unsigned mon_cyc = 0;
    logic [7:0]  mon_rdata = '0;
    logic        mon_err = 1'b0;
    logic        mon_ready = 1'b0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Free-running cycle counter used for timing checks.
    always @(posedge clk_in) cyc <= cyc + 1;

    // Record every response pulse.
    always @(negedge clk_in) begin
        if (bus_if.rsp_valid_out) begin
            mon_cnt   <= mon_cnt + 1;
            mon_cyc   <= cyc;
            mon_rdata <= bus_if.rsp_rdata_out;
            mon_err   <= bus_if.rsp_err_out;
            mon_ready <= bus_if.req_ready_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int unsigned t);
        do @(negedge clk_in); while (cyc < t);
    endtask

    task automatic do_req(input logic wr, input logic [6:0] addr, input logic [7:0] wd,
                          output int unsigned hs);
        @(negedge clk_in);
        bus_if.req_valid_in = 1'b1;
        bus_if.req_write_in = wr;
        bus_if.req_addr_in  = addr;
        bus_if.req_wdata_in = wd;
        @(posedge clk_in);
        #1;
        hs = cyc;
        bus_if.req_valid_in = 1'b0;
    endtask

    task automatic get_frame(input int unsigned t0, output logic [9:0] f);
        for (int j = 0; j < 10; j++) begin
            wait_until(t0 + CPB * j + 1);
            f[j] = tx_out;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk_in);
        end
        rx_in = stop;
        repeat (CPB) @(negedge clk_in);
        rx_in = 1'b1;
    endtask

    task automatic wait_rsp(input int base, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            #1;
            if (mon_cnt != base) begin
                got = 1'b1;
                break;
            end
        end
        check("rsp_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int unsigned hs;
        int          base;
        logic [9:0]  fr;

        rst_in_n            = 1'b0;
        rx_in               = 1'b1;
        bus_if.req_valid_in = 1'b0;
        bus_if.req_write_in = 1'b0;
        bus_if.req_addr_in  = '0;
        bus_if.req_wdata_in = '0;
        repeat (3) @(negedge clk_in);
        check("rst_tx", 32'(tx_out), 32'd1);
        check("rst_ready", 32'(bus_if.req_ready_out), 32'd1);
        check("rst_busy", 32'(bus_if.busy_out), 32'd0);
        check("rst_valid", 32'(bus_if.rsp_valid_out), 32'd0);
        check("rst_rdata", 32'(bus_if.rsp_rdata_out), 32'h00);
        check("rst_err", 32'(bus_if.rsp_err_out), 32'd0);
        rst_in_n = 1'b1;
        repeat (3) @(negedge clk_in);

        // Write 0x3C to 0x05, good ack.
        base = mon_cnt;
        do_req(1'b1, 7'h05, 8'h3C, hs);
        check("wr_busy", 32'(bus_if.busy_out), 32'd1);
        get_frame(hs, fr);
        check("wr_cmd_frame", 32'(fr), 32'({1'b1, 8'h85, 1'b0}));
        get_frame(hs + 40, fr);
        check("wr_data_frame", 32'(fr), 32'({1'b1, 8'h3C, 1'b0}));
        wait_until(hs + 90);
        send_byte(8'hAA, 1'b1);
        wait_rsp(base, 60);
        check("wr_rdata", 32'(mon_rdata), 32'hAA);
        check("wr_err", 32'(mon_err), 32'd0);
        repeat (5) @(negedge clk_in);
        check("wr_one_pulse", 32'(mon_cnt), 32'(base + 1));

        // Read 0x12 with request held during busy.
        base = mon_cnt;
        do_req(1'b0, 7'h12, 8'h00, hs);
        check("rd_ready_low", 32'(bus_if.req_ready_out), 32'd0);
        bus_if.req_valid_in = 1'b1;
        bus_if.req_write_in = 1'b1;
        bus_if.req_addr_in  = 7'h7F;
        bus_if.req_wdata_in = 8'hFF;
        get_frame(hs, fr);
        bus_if.req_valid_in = 1'b0;
        check("rd_cmd_frame", 32'(fr), 32'({1'b1, 8'h12, 1'b0}));
        wait_until(hs + 50);
        send_byte(8'h7E, 1'b1);
        wait_rsp(base, 60);
        check("rd_rdata", 32'(mon_rdata), 32'h7E);
        check("rd_err", 32'(mon_err), 32'd0);
        check("rd_ready_at_pulse", 32'(mon_ready), 32'd0);
        @(negedge clk_in);
        check("rd_ready_after", 32'(bus_if.req_ready_out), 32'd1);
        check("rd_rdata_held", 32'(bus_if.rsp_rdata_out), 32'h7E);
        check("rd_one_pulse", 32'(mon_cnt), 32'(base + 1));

        // Read with no reply: timeout 50 cycles after the stop bit ends.
        base = mon_cnt;
        do_req(1'b0, 7'h20, 8'h00, hs);
        wait_rsp(base, 150);
        check("to_latency", mon_cyc - hs, 32'd90);
        check("to_err", 32'(mon_err), 32'd1);
        check("to_rdata", 32'(mon_rdata), 32'h00);

        // Read with a glitch then a reply with a bad stop bit.
        base = mon_cnt;
        do_req(1'b0, 7'h33, 8'h00, hs);
        wait_until(hs + 45);
        rx_in = 1'b0;
        @(negedge clk_in);
        rx_in = 1'b1;
        wait_until(hs + 55);
        send_byte(8'h81, 1'b0);
        wait_rsp(base, 60);
        check("gl_rdata", 32'(mon_rdata), 32'h81);
        check("gl_err", 32'(mon_err), 32'd1);
        repeat (5) @(negedge clk_in);

        // Write answered with a wrong ack byte.
        base = mon_cnt;
        do_req(1'b1, 7'h0A, 8'hF0, hs);
        wait_until(hs + 90);
        send_byte(8'h55, 1'b1);
        wait_rsp(base, 60);
        check("bad_rdata", 32'(mon_rdata), 32'h55);
        check("bad_err", 32'(mon_err), 32'd1);
        repeat (5) @(negedge clk_in);

        // Reset during data bit 3 of a write, then a normal read.
        base = mon_cnt;
        do_req(1'b1, 7'h07, 8'h60, hs);
        wait_until(hs + CPB * 14 + 1);
        check("mid_tx_low", 32'(tx_out), 32'd0);
        rst_in_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_out), 32'd1);
        check("mid_rst_ready", 32'(bus_if.req_ready_out), 32'd1);
        check("mid_rst_busy", 32'(bus_if.busy_out), 32'd0);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        repeat (100) @(negedge clk_in);
        check("mid_no_pulse", 32'(mon_cnt), 32'(base));
        check("mid_ready", 32'(bus_if.req_ready_out), 32'd1);
        do_req(1'b0, 7'h44, 8'h00, hs);
        get_frame(hs, fr);
        check("post_cmd_frame", 32'(fr), 32'({1'b1, 8'h44, 1'b0}));
        wait_until(hs + 50);
        send_byte(8'hC3, 1'b1);
        wait_rsp(base, 60);
        check("post_rdata", 32'(mon_rdata), 32'hC3);
        check("post_err", 32'(mon_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/uart_reg_master.md
Name: uart_reg_master

Overview:
- UART command initiator that drives the generator's UART register bank from the host side.
- Turns parallel register read/write requests into 8N1 byte sequences on tx_out.
- Receives and checks the responder's reply on rx_in, then returns a one-cycle response pulse.
- Used on the companion/test FPGA and as the bench driver for the register-bank path.

Parameters:
CLKS_PER_BIT, 142, clock cycles per UART bit (must be >= 4)
RSP_TIMEOUT, 20000, cycles allowed from end of last transmitted stop bit to start-bit detection of reply

Ports:
clk_in  input  1  system clock
rst_in_n  input  1  asynchronous active-low reset
req_valid_in  input  1  request strobe, accepted when req_ready_out=1
req_ready_out  output  1  high only in IDLE
req_write_in  input  1  1=write, 0=read
req_addr_in  input  7  register address
req_wdata_in  input  8  write data (ignored for read)
rsp_valid_out  output  1  one-cycle response pulse
rsp_rdata_out  output  8  read data (0xAA for successful write), held until next rsp_valid_out
rsp_err_out  output  1  valid with rsp_valid_out: timeout, framing error or bad ack
busy_out  output  1  ~req_ready_out
tx_out  output  1  UART TX, idle high
rx_in  input  1  UART RX, asynchronous to clk_in

Behaviour:
- Reset (async): tx_out=1, req_ready_out=1, busy_out=0, rsp_valid_out=0, rsp_rdata_out=0x00, rsp_err_out=0, FSM=IDLE. All counters cleared.
- Reset mid-frame abandons the transaction immediately; tx_out returns high in the same instant.
- Protocol (8N1, LSB first):
  - Command byte = {req_write_in, req_addr_in}.
  - Write: cmd byte, then data byte; responder replies 0xAA.
  - Read: cmd byte only; responder replies the register value.
- Request capture: handshake when req_valid_in & req_ready_out at a clock edge; write/addr/wdata are latched at that edge.
- FSM:
  - IDLE -> SEND_CMD on handshake.
  - SEND_CMD -> SEND_DATA (write) or WAIT_RSP (read) at end of stop bit.
  - SEND_DATA -> WAIT_RSP at end of stop bit.
  - WAIT_RSP -> RECV on start-bit detect, or -> DONE with err on timeout.
  - RECV -> DONE after stop-bit sample.
  - DONE -> IDLE after one cycle; rsp_valid_out=1 during DONE.
- TX timing:
  - Start bit drives tx_out low in the cycle after the handshake.
  - Each bit lasts exactly CLKS_PER_BIT cycles; frame = 10 bits.
  - Data byte start bit follows the cmd stop bit with no gap.
- RX path:
  - rx_in passes through a 2-flop synchronizer before any use.
  - A falling edge on the synchronized line while in WAIT_RSP arms reception.
  - Start bit is re-sampled at CLKS_PER_BIT/2 (integer division). If it is high: false start, return to WAIT_RSP; the timeout counter is NOT reset.
  - Data bits are sampled at bit centres; the stop bit is sampled at its centre.
  - DONE is entered at the stop-bit centre sample.
- Timeout: counter starts at 0 on the cycle after the last TX stop bit ends and increments each cycle in WAIT_RSP. Reaching RSP_TIMEOUT-1 without a start detect gives rsp_err_out=1, rsp_rdata_out=0x00.
- Errors:
  - Stop bit sampled 0: rsp_err_out=1; the received byte is still presented.
  - Write whose reply != 0xAA: rsp_err_out=1; the received byte is presented.
  - Read: any byte with a good stop bit is rsp_err_out=0.
- Activity on rx_in outside WAIT_RSP/RECV is ignored, including while transmitting.
- req_valid_in asserted while busy is not accepted and has no effect.
- Latency from handshake to rsp_valid_out: write = 20*CLKS_PER_BIT + reply-dependent; no fixed bound beyond timeout + 10*CLKS_PER_BIT + 3 synchronizer/edge cycles.

Test Plan:
- CLKS_PER_BIT=4, write addr 0x05 data 0x3C, model replies 0xAA after 10 cycles -> tx shows 0x85 then 0x3C frames, 4 cycles/bit, no gap; one rsp_valid_out pulse with rdata=0xAA, err=0.
- Read addr 0x12, model replies 0x7E -> tx frame 0x12 only; rsp rdata=0x7E, err=0; req_ready_out low from handshake to the cycle after the pulse.
- Write, model replies 0x55 -> rsp err=1, rdata=0x55.
- RSP_TIMEOUT=50, read with no reply -> rsp_valid_out exactly 50 cycles after the TX stop bit ends; err=1, rdata=0x00.
- Read, model sends a 1-cycle low glitch, then a valid 0x81 reply with stop bit forced 0 -> glitch rejected as false start; rsp err=1, rdata=0x81.
- Assert rst_in_n low mid data bit 3 of a write -> tx_out=1 immediately; after release, req_ready_out=1 and no rsp_valid_out occurs; the next read completes normally.
